// File: rtl/sample_pkg.sv
// Shared sample width and per-bank state type for the ADC sample frame buffer.
package sample_pkg;

  localparam int SAMPLE_W = 12;

  typedef enum logic [1:0] {
    FILL,
    HELD,
    FREE
  } bank_state_t;

endpackage

// File: rtl/frame_bank_ram.sv
// Simple dual-port sample RAM holding both ping-pong banks; the address MSB selects the bank.
module frame_bank_ram
  import sample_pkg::*;
#(
  parameter int AW = 9,
  parameter int DW = SAMPLE_W
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Output register only loads while a frame is held, so it never picks up unwritten RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sample_frame_buffer.sv
// Packs delayed ADC samples into ping-pong frame banks and hands completed frames to a consumer.
// Optional OVERRUN_COUNT_EN adds a saturating dropped-frame counter output.
module sample_frame_buffer
  import sample_pkg::*;
#(
  parameter int FRAME_LEN     = 256,
  parameter int CAPTURE_DELAY = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [SAMPLE_W-1:0]          sample_in,
  input  logic                         new_sample_in,
  output logic                         frame_valid,
  input  logic [$clog2(FRAME_LEN)-1:0] rd_addr,
  output logic [SAMPLE_W-1:0]          rd_data,
  input  logic                         frame_release,
  output logic                         overrun
`ifdef OVERRUN_COUNT_EN
  ,output logic [15:0]                 overrun_count
`endif
);

  localparam int AW = $clog2(FRAME_LEN);
  localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);

  logic          wbank;
  logic          held_bank;
  logic [AW-1:0] widx;
  bank_state_t   bank_st [2];
  logic          wr_en;
  logic          release_eff;
  logic          frame_done;
  logic          swap_ok;

  assign held_bank   = ~wbank;
  assign release_eff = frame_release & frame_valid;
  assign frame_done  = wr_en && (widx == LAST_IDX);
  // A release in the completing cycle frees the other bank before the swap decision.
  assign swap_ok     = (bank_st[held_bank] == FREE) || release_eff;

  if (CAPTURE_DELAY == 0) begin : g_no_delay
    assign wr_en = new_sample_in;
  end else begin : g_delay
    localparam logic [2:0] CNT_INIT = 3'(CAPTURE_DELAY - 1);
    logic       armed;
    logic [2:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        armed <= 1'b0;
        cnt   <= '0;
      end else if (armed) begin
        if (cnt == 3'd0) armed <= 1'b0;
        else cnt <= cnt - 1'b1;
      end else if (new_sample_in) begin
        armed <= 1'b1;
        cnt   <= CNT_INIT;
      end
    end

    assign wr_en = armed && (cnt == 3'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wbank       <= 1'b0;
      widx        <= '0;
      bank_st[0]  <= FILL;
      bank_st[1]  <= FREE;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (frame_done) begin
        widx <= '0;
        if (swap_ok) begin
          bank_st[wbank]     <= HELD;
          bank_st[held_bank] <= FILL;
          wbank              <= held_bank;
          frame_valid        <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else begin
        if (wr_en) widx <= widx + 1'b1;
        if (release_eff) begin
          bank_st[held_bank] <= FREE;
          frame_valid        <= 1'b0;
        end
      end
    end
  end

`ifdef OVERRUN_COUNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) overrun_count <= '0;
    else if (release_eff) overrun_count <= '0;
    else if (frame_done && !swap_ok && overrun_count != 16'hFFFF)
      overrun_count <= overrun_count + 1'b1;
  end
`endif

  frame_bank_ram #(
    .AW(AW + 1),
    .DW(SAMPLE_W)
  ) u_ram (
    .clk    (clk),
    .reset_n(reset_n),
    .wr_en  (wr_en),
    .wr_addr({wbank, widx}),
    .wr_data(sample_in),
    .rd_en  (frame_valid),
    .rd_addr({held_bank, rd_addr}),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_sample_frame_buffer.sv
// Randomized self-checking bench for sample_frame_buffer against a frame-level queue model.
module tb_sample_frame_buffer;

  localparam int FL = 8;
  localparam int DLY = 2;

  logic        clk;
  logic        reset_n;
  logic [11:0] sample_in;
  logic        new_sample_in;
  logic        frame_valid;
  logic [2:0]  rd_addr;
  logic [11:0] rd_data;
  logic        frame_release;
  logic        overrun;
`ifdef OVERRUN_COUNT_EN
  logic [15:0] overrun_count;
`endif

  int n_checks;
  int n_pass;

  // Reference model: samples of the frame being filled, the held frame, and drop counter.
  logic [11:0] m_fill [$];
  logic [11:0] m_held [FL];
  bit          m_valid;
  int          m_count;

  sample_frame_buffer #(
    .FRAME_LEN    (FL),
    .CAPTURE_DELAY(DLY)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_in    (sample_in),
    .new_sample_in(new_sample_in),
    .frame_valid  (frame_valid),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .frame_release(frame_release),
    .overrun      (overrun)
`ifdef OVERRUN_COUNT_EN
    ,.overrun_count(overrun_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic checkCount();
`ifdef OVERRUN_COUNT_EN
    checkOutput("overrun_count", overrun_count, 16'(m_count));
`endif
  endtask

  // Pulse new_sample_in, optionally glitch sample_in and re-pulse while armed, and
  // optionally release in the write cycle. Called and returns at a negedge.
  task automatic applyStimulus(input logic [11:0] v, input bit glitch, input bit dbl, input bit rel);
    bit exp_over;
    exp_over = 1'b0;
    new_sample_in = 1'b1;
    sample_in     = glitch ? 12'hAAA : v;
    @(negedge clk);
    new_sample_in = dbl;
    sample_in     = v;
    @(negedge clk);
    new_sample_in = 1'b0;
    frame_release = rel;
    @(negedge clk);
    frame_release = 1'b0;
    if (rel && m_valid) begin
      m_valid = 1'b0;
      m_count = 0;
    end
    m_fill.push_back(v);
    if (m_fill.size() == FL) begin
      if (!m_valid) begin
        for (int i = 0; i < FL; i++) m_held[i] = m_fill[i];
        m_valid = 1'b1;
      end else begin
        exp_over = 1'b1;
        if (m_count < 65535) m_count++;
      end
      m_fill.delete();
    end
    checkOutput("frame_valid", {15'd0, frame_valid}, {15'd0, m_valid});
    checkOutput("overrun", {15'd0, overrun}, {15'd0, exp_over});
    checkCount();
    @(negedge clk);
    checkOutput("overrun_width", {15'd0, overrun}, 16'd0);
  endtask

  task automatic releaseFrame();
    frame_release = 1'b1;
    @(negedge clk);
    frame_release = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0;
      m_count = 0;
    end
    checkOutput("release_valid", {15'd0, frame_valid}, {15'd0, m_valid});
    checkCount();
  endtask

  task automatic readCheck(input logic [2:0] a);
    rd_addr = a;
    @(negedge clk);
    if (m_valid) checkOutput("rd_data", {4'd0, rd_data}, {4'd0, m_held[a]});
  endtask

  task automatic sendRandom(input bit rel);
    applyStimulus(12'($urandom), 1'($urandom), 1'($urandom), rel);
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    m_valid = 1'b0;
    m_count = 0;
    clk = 1'b0;
    reset_n = 1'b0;
    sample_in = '0;
    new_sample_in = 1'b0;
    frame_release = 1'b0;
    rd_addr = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_valid", {15'd0, frame_valid}, 16'd0);
    checkOutput("reset_overrun", {15'd0, overrun}, 16'd0);
    checkOutput("reset_rd_data", {4'd0, rd_data}, 16'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Ascending frame, then a specific read.
    for (int i = 0; i < FL; i++) applyStimulus(12'h100 + 12'(i), 1'b0, 1'b0, 1'b0);
    readCheck(3'd3);
    checkOutput("rd_0x103", {4'd0, rd_data}, 16'h0103);

    // Late-changing input and an ignored second pulse, then no release for two frames.
    applyStimulus(12'h555, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2 * FL - 1; i++) sendRandom(1'b0);
    for (int i = 0; i < FL; i++) readCheck(3'(i));

    // Release coinciding with the completing write of a frame.
    for (int i = 0; i < FL - 1; i++) sendRandom(1'b0);
    sendRandom(1'b1);
    for (int i = 0; i < FL; i++) readCheck(3'(i));

    for (int it = 0; it < 120; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 15) releaseFrame();
      else if (r < 35) readCheck(3'($urandom));
      else sendRandom($urandom_range(0, 9) == 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset in the middle of a frame.
    releaseFrame();
    for (int i = 0; i < 5; i++) sendRandom(1'b0);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_valid", {15'd0, frame_valid}, 16'd0);
    checkOutput("midreset_overrun", {15'd0, overrun}, 16'd0);
    m_fill.delete();
    m_valid = 1'b0;
    m_count = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < FL; i++) sendRandom(1'b0);
    for (int i = 0; i < FL; i++) readCheck(3'(i));

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
